// File: rtl/uart_tx_framer_if.sv
// uart_tx_framer_if: tick/start/data in, serial line and status out.
// master drives the request side, slave is the framer.
interface uart_tx_framer_if #(
  parameter int DATA_W = 8
);
  logic              baud_tick;
  logic              start;
  logic [DATA_W-1:0] data;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    output baud_tick,
    output start,
    output data,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  baud_tick,
    input  start,
    input  data,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: async serial transmitter clocked by an external baud strobe.
// Frame = start, DATA_W bits LSB first, optional parity, STOP_BITS stops.
module uart_tx_framer #(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic             clk,
  input logic             rst_n,
  uart_tx_framer_if.slave bus
);

  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);
  localparam logic SLAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic              start_q;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              par_q, par_d;
  logic              stop_q, stop_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IW-1:0]     idx_q, idx_d;

  logic accept;
  logic par_calc;

  assign accept = bus.start && !start_q
                  && (state_q == S_IDLE);

  assign par_calc = (PARITY == 2) ? ~^bus.data
                                  : ^bus.data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= bus.start;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    par_d   = par_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          shift_d = bus.data;
          par_d   = par_calc;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      // first tick after accept only sets the bit phase
      S_WAIT: begin
        if (bus.baud_tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bus.baud_tick) begin
          tx_d    = shift_q[0];
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.baud_tick) begin
          if (idx_q != LAST) begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            idx_d   = idx_q + 1'b1;
          end else if (PARITY != 0) begin
            tx_d    = par_q;
            state_d = S_PAR;
          end else begin
            tx_d    = 1'b1;
            stop_d  = 1'b0;
            state_d = S_STOP;
          end
        end
      end
      S_PAR: begin
        if (bus.baud_tick) begin
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bus.baud_tick) begin
          if (stop_q == SLAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Serial transmitter stage directly downstream of the baud tick generator.
- Consumes the one-cycle baud strobe and a start request from the board button.
- Shifts a latched data word onto the `tx` line as an async serial frame: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
- The default frame is 10 bit-times (8N1), which matches the generator's 10-tick frame budget at 9600 baud on the 25 MHz clock.

Parameters:
- DATA_W, 8, number of data bits per frame (5..9)
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, number of stop bit-times (1 or 2)

Ports:
- clk  input  1  system clock, 25 MHz
- rst_n  input  1  asynchronous active-low reset
- baud_tick  input  1  one-clk-wide strobe, once per bit period, from the tick generator
- start  input  1  transmit request, raw level (button); only its rising edge is acted on
- data  input  DATA_W  word to transmit, sampled on the accept cycle only
- tx  output  1  serial line, idle high
- busy  output  1  high from the accept cycle until frame completion
- done  output  1  one-cycle pulse when the final stop bit-time ends

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - tx=1, busy=0, done=0, state=IDLE.
  - Shift register and counters are 0.
  - start_q=1, so a button held through reset must be released and pressed again before a frame is sent.
- Edge detect: start_q <= start every cycle. An accept event is start && !start_q while state==IDLE.
- State machine: IDLE -> WAIT -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - tx=1.
  - On accept: latch data into the shift register, compute the parity bit from the latched data, set busy<=1, go to WAIT.
- WAIT:
  - Aligns the frame to the tick phase.
  - A baud_tick in the accept cycle itself is ignored.
  - On the first baud_tick seen in WAIT: tx<=0, go to START.
- START: on baud_tick, tx<=shift[0], bit_idx<=0, go to DATA.
- DATA:
  - On baud_tick with bit_idx<DATA_W-1: shift right, tx<=next bit, bit_idx++.
  - On baud_tick with bit_idx==DATA_W-1:
    - PARITY!=0: tx<=parity bit, go to PARITY.
    - PARITY==0: tx<=1, stop_cnt<=0, go to STOP.
- PARITY: on baud_tick, tx<=1, stop_cnt<=0, go to STOP.
- STOP:
  - On baud_tick with stop_cnt==STOP_BITS-1: busy<=0, done<=1 for one cycle, go to IDLE.
  - Otherwise, on baud_tick: stop_cnt++.
  - tx stays 1 throughout.
- Parity arithmetic:
  - even: parity bit = XOR of the DATA_W data bits.
  - odd: parity bit = inverted XOR of the data bits.
- Timing:
  - Every bit occupies exactly one baud period (tick to tick).
  - done asserts in the cycle after the tick numbered 2+DATA_W+(PARITY!=0)+STOP_BITS counted from accept. Default: 11 ticks (1 alignment + 10 bit-times).
- Boundary conditions:
  - Start rising edge while busy: ignored and not queued. start_q keeps tracking, so the edge is lost.
  - Start held high after a frame: no retransmit until a new rising edge.
  - data changes while busy: no effect.
  - Accept possible in the cycle right after done, since state is IDLE again.
  - baud_tick in IDLE: no effect.
  - Reset mid-frame: tx returns to 1 immediately (async), busy=0, done=0. No partial frame resumes.
- State encoding: one-hot or binary. All outputs are registered; no combinational path from inputs to tx.

Test Plan:
- Reset idle: rst_n=0 with start=1 held, then release rst_n, start held 20 cycles -> tx=1, busy=0, no frame sent. Then start 0->1 -> accept.
- 8N1 frame: baud_tick every 4 clk, data=0xA5, start pulse -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 clk wide; done pulses once, 11 ticks after accept; busy low the same cycle as done.
- Even parity: PARITY=1, data=0x07 -> parity bit 1. Odd parity: PARITY=2, data=0x07 -> parity bit 0. Frame length is 11 bit-times in both cases.
- Two stop bits: STOP_BITS=2, data=0x00 -> tx high for 8 clk after the last data bit before done; total 12 ticks from accept to done.
- Busy collision: second start edge with data=0xFF mid-frame -> ignored, frame carries only 0xA5. Third edge one cycle after done -> accepted, frame carries the newly sampled data.
- Reset mid-frame: rst_n=0 during the DATA state -> tx=1 and busy=0 in the same cycle, no done pulse. After release, a new start edge produces a complete, correct frame.
